// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, instruction
// classes, opcode/funct constants and the PCSrc / Cause codes.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EX_R   = 4'd2,
    S_EX_I   = 4'd3,
    S_WB_R   = 4'd4,
    S_WB_I   = 4'd5,
    S_ADDR   = 4'd6,
    S_MEM_RD = 4'd7,
    S_MEM_WR = 4'd8,
    S_WB_MEM = 4'd9,
    S_BR     = 4'd10,
    S_JMP    = 4'd11,
    S_JR     = 4'd12,
    S_EXC    = 4'd13
  } state_t;

  typedef enum logic [2:0] {
    C_R   = 3'd0,
    C_I   = 3'd1,
    C_LD  = 3'd2,
    C_ST  = 3'd3,
    C_BR  = 3'd4,
    C_J   = 3'd5,
    C_JR  = 3'd6
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  localparam logic [2:0] PCSRC_ALU    = 3'b000;
  localparam logic [2:0] PCSRC_ALUOUT = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_RS     = 3'b011;
  localparam logic [2:0] PCSRC_IRQ    = 3'b100;
  localparam logic [2:0] PCSRC_EXC    = 3'b101;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_IRQ   = 2'b01;
  localparam logic [1:0] CAUSE_UNDEF = 2'b10;
  localparam logic [1:0] CAUSE_BUS   = 2'b11;

  // R-type functs the datapath implements: sll/srl/sra, jr/jalr, 0x20-0x27, slt/sltu.
  function automatic logic funct_defined(input logic [5:0] f);
    return (f == 6'h00) || (f == 6'h02) || (f == 6'h03) || (f == 6'h08) ||
           (f == 6'h09) || ((f >= 6'h20) && (f <= 6'h27)) ||
           (f == 6'h2a) || (f == 6'h2b);
  endfunction

endpackage

// File: rtl/multicycle_controller_inst_decode.sv
// Combinational opcode/funct classifier consulted by the ID state to pick the
// execution path, flagging anything the datapath cannot run.
module inst_decode
  import multicycle_pkg::*;
(
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  output logic [2:0] iclass,
  output logic       undef
);

  always_comb begin
    iclass = C_R;
    undef  = 1'b0;
    case (op_code)
      OP_RTYPE: begin
        iclass = ((funct == FN_JR) || (funct == FN_JALR)) ? C_JR : C_R;
        undef  = !funct_defined(funct);
      end
      OP_LW:                                   iclass = C_LD;
      OP_SW:                                   iclass = C_ST;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ: iclass = C_BR;
      OP_J, OP_JAL:                            iclass = C_J;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
      OP_SLTI, OP_SLTIU, OP_LUI:               iclass = C_I;
      default:                                 undef = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM with a memory wait/timeout counter and precise
// entry into an exception state for IRQ, undefined instruction and bus timeout.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int   MEM_TIMEOUT = 15,
  parameter logic IRQ_EN      = 1'b1,
  parameter int   CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       IRQ,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] PCSrc,
  output logic       ExtOp,
  output logic       LuOp,
  output logic       EPCWrite,
  output logic [1:0] Cause,
  output logic [3:0] state_o
);

  // Handshake: a memory access is requested by MemRead/MemWrite held high and
  // completes in the first cycle mem_ready is sampled high while requested.

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             irq_take_q, irq_take_d;
  logic             boot_q;
  logic [2:0]       iclass;
  logic             undef;
  logic             irq_req;
  logic             mem_timeout;

  inst_decode u_dec (
    .op_code (OpCode),
    .funct   (Funct),
    .iclass  (iclass),
    .undef   (undef)
  );

  assign irq_req     = IRQ & IRQ_EN;
  assign mem_timeout = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  assign state_o     = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IF;
      cnt_q      <= '0;
      cause_q    <= CAUSE_NONE;
      irq_take_q <= 1'b0;
      boot_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      irq_take_q <= irq_take_d;
      boot_q     <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_IF: begin
        if (boot_q) begin
          state_d = S_IF;
        end else if (irq_take_q) begin
          state_d = S_EXC;
          cause_d = CAUSE_IRQ;
        end else if (mem_ready) begin
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (undef) begin
          state_d = S_EXC;
          cause_d = CAUSE_UNDEF;
        end else begin
          case (iclass)
            C_R:        state_d = S_EX_R;
            C_JR:       state_d = S_JR;
            C_LD, C_ST: state_d = S_ADDR;
            C_BR:       state_d = S_BR;
            C_J:        state_d = S_JMP;
            C_I:        state_d = S_EX_I;
            default: begin
              state_d = S_EXC;
              cause_d = CAUSE_UNDEF;
            end
          endcase
        end
      end
      S_EX_R:   state_d = S_WB_R;
      S_EX_I:   state_d = S_WB_I;
      S_ADDR:   state_d = (iclass == C_ST) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD, S_MEM_WR: begin
        // A mem_ready on the final allowed cycle still completes the access.
        if (mem_ready) begin
          state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_IF;
        end else if (mem_timeout) begin
          state_d = S_EXC;
          cause_d = CAUSE_BUS;
        end
      end
      default:  state_d = S_IF;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_MEM_RD) || (state_q == S_MEM_WR)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    // IRQ is sampled only on arrival at an instruction boundary; the return
    // from EXC is excluded so one instruction runs between back-to-back IRQs.
    irq_take_d = (state_d == S_IF) && (state_q != S_IF) && (state_q != S_EXC) && irq_req;
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    MemToReg    = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b01;
    ALUOp       = 2'b00;
    PCSrc       = PCSRC_ALU;
    ExtOp       = 1'b1;
    LuOp        = 1'b0;
    EPCWrite    = 1'b0;
    Cause       = CAUSE_NONE;
    case (state_q)
      S_IF: begin
        if (!boot_q && !irq_take_q) begin
          MemRead = 1'b1;
          ALUOp   = 2'b10;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        ALUOp   = 2'b10;
      end
      S_EX_R: begin
        ALUSrcA = (Funct <= 6'h03) ? 2'b10 : 2'b01;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b00;
      end
      S_EX_I: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        ExtOp   = !((OpCode == OP_ADDIU) || (OpCode == OP_SLTIU) ||
                    (OpCode == OP_ANDI)  || (OpCode == OP_ORI));
        LuOp    = (OpCode == OP_LUI);
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
      end
      S_WB_I:   RegWrite = 1'b1;
      S_ADDR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemToReg = 2'b01;
      end
      S_BR: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSrc       = PCSRC_ALUOUT;
      end
      S_JMP: begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_JUMP;
        if (OpCode == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemToReg = 2'b10;
        end
      end
      S_JR: begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_RS;
        if (Funct == FN_JALR) begin
          RegWrite = 1'b1;
          RegDst   = 2'b01;
          MemToReg = 2'b10;
        end
      end
      S_EXC: begin
        EPCWrite = 1'b1;
        Cause    = cause_q;
        PCWrite  = 1'b1;
        PCSrc    = (cause_q == CAUSE_IRQ) ? PCSRC_IRQ : PCSRC_EXC;
        RegWrite = 1'b1;
        RegDst   = 2'b11;
        MemToReg = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed per-cycle expectations queued by the
// driver and compared by an independent negedge monitor.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, irw, mr, mw, rw;
    logic [1:0] rdst, m2r, asa, asb, aop;
    logic [2:0] pcs;
    logic       ext, lu, epcw;
    logic [1:0] cause;
  } obs_t;
  localparam int W = $bits(obs_t);

  localparam logic [3:0] ST_IF = 4'd0, ST_ID = 4'd1, ST_EX_R = 4'd2, ST_EX_I = 4'd3,
                         ST_WB_R = 4'd4, ST_WB_I = 4'd5, ST_ADDR = 4'd6,
                         ST_MEM_RD = 4'd7, ST_MEM_WR = 4'd8, ST_WB_MEM = 4'd9,
                         ST_BR = 4'd10, ST_JMP = 4'd11, ST_JR = 4'd12, ST_EXC = 4'd13;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reset2 = 1'b1;
  logic [5:0] OpCode = 6'h00;
  logic [5:0] Funct = 6'h00;
  logic       IRQ = 1'b0;
  logic       mem_ready = 1'b0;

  logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, RegWrite;
  logic [1:0] RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUOp, Cause;
  logic [2:0] PCSrc;
  logic       ExtOp, LuOp, EPCWrite;
  logic [3:0] state_o;

  logic       n_pcw, n_pcwc, n_iord, n_irw, n_mr, n_mw, n_rw;
  logic [1:0] n_rdst, n_m2r, n_asa, n_asb, n_aop, n_cause;
  logic [2:0] n_pcs;
  logic       n_ext, n_lu, n_epcw;
  logic [3:0] n_st;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp2_q[$];
  string        nm_q[$];
  string        nm2_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  int           cyc_no = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(15), .IRQ_EN(1'b1), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .IRQ(IRQ),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .ExtOp(ExtOp), .LuOp(LuOp),
    .EPCWrite(EPCWrite), .Cause(Cause), .state_o(state_o)
  );

  multicycle_controller #(.MEM_TIMEOUT(15), .IRQ_EN(1'b0), .CNT_W(8)) u_dut_noirq (
    .clk(clk), .reset(reset2), .OpCode(OpCode), .Funct(Funct), .IRQ(IRQ),
    .mem_ready(mem_ready), .PCWrite(n_pcw), .PCWriteCond(n_pcwc),
    .IorD(n_iord), .IRWrite(n_irw), .MemRead(n_mr), .MemWrite(n_mw),
    .RegWrite(n_rw), .RegDst(n_rdst), .MemToReg(n_m2r), .ALUSrcA(n_asa),
    .ALUSrcB(n_asb), .ALUOp(n_aop), .PCSrc(n_pcs), .ExtOp(n_ext), .LuOp(n_lu),
    .EPCWrite(n_epcw), .Cause(n_cause), .state_o(n_st)
  );

  obs_t obs1, obs2;
  assign obs1 = {state_o, PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
                 RegWrite, RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
                 ExtOp, LuOp, EPCWrite, Cause};
  assign obs2 = {n_st, n_pcw, n_pcwc, n_iord, n_irw, n_mr, n_mw, n_rw, n_rdst,
                 n_m2r, n_asa, n_asb, n_aop, n_pcs, n_ext, n_lu, n_epcw, n_cause};

  // Expected per-state output vectors.
  function automatic obs_t e_rst(input logic [3:0] st);
    obs_t e;
    e = '0;
    e.st = st; e.asb = 2'b01; e.ext = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_fetch(input logic rdy);
    obs_t e;
    e = e_rst(ST_IF);
    e.mr = 1'b1; e.aop = 2'b10; e.irw = rdy; e.pcw = rdy;
    return e;
  endfunction
  function automatic obs_t e_id();
    obs_t e;
    e = e_rst(ST_ID);
    e.asb = 2'b11; e.aop = 2'b10;
    return e;
  endfunction
  function automatic obs_t e_exr(input logic [1:0] asa);
    obs_t e;
    e = e_rst(ST_EX_R);
    e.asa = asa; e.asb = 2'b00; e.aop = 2'b00;
    return e;
  endfunction
  function automatic obs_t e_exi(input logic ext, input logic lu);
    obs_t e;
    e = e_rst(ST_EX_I);
    e.asa = 2'b01; e.asb = 2'b10; e.aop = 2'b11; e.ext = ext; e.lu = lu;
    return e;
  endfunction
  function automatic obs_t e_wb(input logic [3:0] st, input logic [1:0] rdst, input logic [1:0] m2r);
    obs_t e;
    e = e_rst(st);
    e.rw = 1'b1; e.rdst = rdst; e.m2r = m2r;
    return e;
  endfunction
  function automatic obs_t e_addr();
    obs_t e;
    e = e_rst(ST_ADDR);
    e.asa = 2'b01; e.asb = 2'b10; e.aop = 2'b10;
    return e;
  endfunction
  function automatic obs_t e_mem(input logic wr);
    obs_t e;
    e = e_rst(wr ? ST_MEM_WR : ST_MEM_RD);
    e.iord = 1'b1; e.mr = !wr; e.mw = wr;
    return e;
  endfunction
  function automatic obs_t e_br();
    obs_t e;
    e = e_rst(ST_BR);
    e.asa = 2'b01; e.asb = 2'b00; e.aop = 2'b01; e.pcwc = 1'b1; e.pcs = 3'b001;
    return e;
  endfunction
  function automatic obs_t e_jump(input logic [3:0] st, input logic link);
    obs_t e;
    e = e_rst(st);
    e.pcw = 1'b1;
    e.pcs = (st == ST_JMP) ? 3'b010 : 3'b011;
    if (link) begin
      e.rw = 1'b1; e.m2r = 2'b10;
      e.rdst = (st == ST_JMP) ? 2'b10 : 2'b01;
    end
    return e;
  endfunction
  function automatic obs_t e_exc(input logic [1:0] cause);
    obs_t e;
    e = e_rst(ST_EXC);
    e.epcw = 1'b1; e.cause = cause; e.pcw = 1'b1;
    e.pcs = (cause == 2'b01) ? 3'b100 : 3'b101;
    e.rw = 1'b1; e.rdst = 2'b11; e.m2r = 2'b10;
    return e;
  endfunction

  // One clock cycle: drive inputs, queue the expected outputs for this cycle.
  task automatic cyc(input obs_t e, input logic rdy, input logic irq, input string nm,
                     input bit dut2 = 1'b0);
    mem_ready = rdy;
    IRQ = irq;
    if (dut2) begin
      exp2_q.push_back(e); nm2_q.push_back(nm);
    end else begin
      exp_q.push_back(e); nm_q.push_back(nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [5:0] op, input logic [5:0] fn);
    OpCode = op;
    Funct = fn;
  endtask

  always @(negedge clk) begin
    cyc_no <= cyc_no + 1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] ex;
      string nm;
      ex = exp_q.pop_front();
      nm = nm_q.pop_front();
      n_checks++;
      if (obs1 === ex) n_pass++;
      else $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc_no, obs1, ex);
    end
    if (exp2_q.size() > 0) begin
      logic [W-1:0] ex;
      string nm;
      ex = exp2_q.pop_front();
      nm = nm2_q.pop_front();
      n_checks++;
      if (obs2 === ex) n_pass++;
      else $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc_no, obs2, ex);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(e_rst(ST_IF), 1'b1, 1'b0, "reset_if");

    // addu: four cycles, RegWrite only in WB_R
    set_inst(6'h00, 6'h21);
    cyc(e_fetch(1'b1), 1'b1, 1'b0, "addu_if");
    cyc(e_id(), 1'b0, 1'b0, "addu_id");
    cyc(e_exr(2'b01), 1'b0, 1'b0, "addu_ex");
    cyc(e_wb(ST_WB_R, 2'b01, 2'b00), 1'b0, 1'b0, "addu_wb");

    // lw: data access stalls three cycles
    set_inst(6'h23, 6'h00);
    cyc(e_fetch(1'b1), 1'b1, 1'b0, "lw_if");
    cyc(e_id(), 1'b0, 1'b0, "lw_id");
    cyc(e_addr(), 1'b0, 1'b0, "lw_addr");
    for (int i = 0; i < 3; i++) cyc(e_mem(1'b0), 1'b0, 1'b0, "lw_wait");
    cyc(e_mem(1'b0), 1'b1, 1'b0, "lw_done");
    cyc(e_wb(ST_WB_MEM, 2'b00, 2'b01), 1'b0, 1'b0, "lw_wb");

    // sw never acknowledged: bus timeout after 15 waiting cycles
    set_inst(6'h2b, 6'h00);
    cyc(e_fetch(1'b1), 1'b1, 1'b0, "swto_if");
    cyc(e_id(), 1'b0, 1'b0, "swto_id");
    cyc(e_addr(), 1'b0, 1'b0, "swto_addr");
    for (int i = 0; i < 15; i++) cyc(e_mem(1'b1), 1'b0, 1'b0, "swto_wait");
    cyc(e_exc(2'b11), 1'b0, 1'b0, "swto_exc");

    // sw acknowledged on the timeout cycle itself: completion wins
    cyc(e_fetch(1'b1), 1'b1, 1'b0, "swlate_if");
    cyc(e_id(), 1'b0, 1'b0, "swlate_id");
    cyc(e_addr(), 1'b0, 1'b0, "swlate_addr");
    for (int i = 0; i < 14; i++) cyc(e_mem(1'b1), 1'b0, 1'b0, "swlate_wait");
    cyc(e_mem(1'b1), 1'b1, 1'b0, "swlate_done");

    // undefined opcode and undefined funct
    set_inst(6'h10, 6'h00);
    cyc(e_fetch(1'b1), 1'b1, 1'b0, "undop_if");
    cyc(e_id(), 1'b0, 1'b0, "undop_id");
    cyc(e_exc(2'b10), 1'b0, 1'b0, "undop_exc");
    set_inst(6'h00, 6'h18);
    cyc(e_fetch(1'b1), 1'b1, 1'b0, "undfn_if");
    cyc(e_id(), 1'b0, 1'b0, "undfn_id");
    cyc(e_exc(2'b10), 1'b0, 1'b0, "undfn_exc");

    // other instruction paths
    set_inst(6'h00, 6'h00);
    cyc(e_fetch(1'b1), 1'b1, 1'b0, "sll_if");
    cyc(e_id(), 1'b0, 1'b0, "sll_id");
    cyc(e_exr(2'b10), 1'b0, 1'b0, "sll_ex");
    cyc(e_wb(ST_WB_R, 2'b01, 2'b00), 1'b0, 1'b0, "sll_wb");
    set_inst(6'h0d, 6'h00);
    cyc(e_fetch(1'b1), 1'b1, 1'b0, "ori_if");
    cyc(e_id(), 1'b0, 1'b0, "ori_id");
    cyc(e_exi(1'b0, 1'b0), 1'b0, 1'b0, "ori_ex");
    cyc(e_wb(ST_WB_I, 2'b00, 2'b00), 1'b0, 1'b0, "ori_wb");
    set_inst(6'h0f, 6'h00);
    cyc(e_fetch(1'b1), 1'b1, 1'b0, "lui_if");
    cyc(e_id(), 1'b0, 1'b0, "lui_id");
    cyc(e_exi(1'b1, 1'b1), 1'b0, 1'b0, "lui_ex");
    cyc(e_wb(ST_WB_I, 2'b00, 2'b00), 1'b0, 1'b0, "lui_wb");
    set_inst(6'h04, 6'h00);
    cyc(e_fetch(1'b0), 1'b0, 1'b0, "beq_if_wait");
    cyc(e_fetch(1'b1), 1'b1, 1'b0, "beq_if");
    cyc(e_id(), 1'b0, 1'b0, "beq_id");
    cyc(e_br(), 1'b0, 1'b0, "beq_br");
    set_inst(6'h03, 6'h00);
    cyc(e_fetch(1'b1), 1'b1, 1'b0, "jal_if");
    cyc(e_id(), 1'b0, 1'b0, "jal_id");
    cyc(e_jump(ST_JMP, 1'b1), 1'b0, 1'b0, "jal_jmp");
    set_inst(6'h00, 6'h09);
    cyc(e_fetch(1'b1), 1'b1, 1'b0, "jalr_if");
    cyc(e_id(), 1'b0, 1'b0, "jalr_id");
    cyc(e_jump(ST_JR, 1'b1), 1'b0, 1'b0, "jalr_jr");

    // IRQ raised mid-instruction, then held across two boundaries
    set_inst(6'h00, 6'h20);
    cyc(e_fetch(1'b1), 1'b1, 1'b0, "irq_if");
    cyc(e_id(), 1'b0, 1'b0, "irq_id");
    cyc(e_exr(2'b01), 1'b0, 1'b1, "irq_ex");
    cyc(e_wb(ST_WB_R, 2'b01, 2'b00), 1'b0, 1'b1, "irq_wb");
    cyc(e_rst(ST_IF), 1'b1, 1'b1, "irq_if_nofetch");
    cyc(e_exc(2'b01), 1'b0, 1'b1, "irq_exc");
    cyc(e_fetch(1'b1), 1'b1, 1'b1, "irq2_if");
    cyc(e_id(), 1'b0, 1'b1, "irq2_id");
    cyc(e_exr(2'b01), 1'b0, 1'b1, "irq2_ex");
    cyc(e_wb(ST_WB_R, 2'b01, 2'b00), 1'b0, 1'b1, "irq2_wb");
    cyc(e_rst(ST_IF), 1'b1, 1'b1, "irq2_if_nofetch");
    cyc(e_exc(2'b01), 1'b0, 1'b1, "irq2_exc");

    // reset during a stalled lw, then a lw acknowledged on its 15th wait cycle
    set_inst(6'h23, 6'h00);
    cyc(e_fetch(1'b1), 1'b1, 1'b0, "rst_lw_if");
    cyc(e_id(), 1'b0, 1'b0, "rst_lw_id");
    cyc(e_addr(), 1'b0, 1'b0, "rst_lw_addr");
    cyc(e_mem(1'b0), 1'b0, 1'b0, "rst_lw_wait");
    cyc(e_mem(1'b0), 1'b0, 1'b0, "rst_lw_wait");
    reset = 1'b1;
    cyc(e_mem(1'b0), 1'b0, 1'b0, "rst_lw_hold");
    reset = 1'b0;
    cyc(e_rst(ST_IF), 1'b1, 1'b0, "rst_mid_if");
    cyc(e_fetch(1'b1), 1'b1, 1'b0, "lw15_if");
    cyc(e_id(), 1'b0, 1'b0, "lw15_id");
    cyc(e_addr(), 1'b0, 1'b0, "lw15_addr");
    for (int i = 0; i < 14; i++) cyc(e_mem(1'b0), 1'b0, 1'b0, "lw15_wait");
    cyc(e_mem(1'b0), 1'b1, 1'b0, "lw15_done");
    cyc(e_wb(ST_WB_MEM, 2'b00, 2'b01), 1'b0, 1'b0, "lw15_wb");

    // IRQ_EN = 0 instance: IRQ held high never diverts the flow
    set_inst(6'h00, 6'h21);
    reset2 = 1'b0;
    cyc(e_rst(ST_IF), 1'b1, 1'b1, "noirq_reset_if", 1'b1);
    cyc(e_fetch(1'b1), 1'b1, 1'b1, "noirq_if", 1'b1);
    cyc(e_id(), 1'b0, 1'b1, "noirq_id", 1'b1);
    cyc(e_exr(2'b01), 1'b0, 1'b1, "noirq_ex", 1'b1);
    cyc(e_wb(ST_WB_R, 2'b01, 2'b00), 1'b0, 1'b1, "noirq_wb", 1'b1);
    cyc(e_fetch(1'b0), 1'b0, 1'b1, "noirq_if2", 1'b1);

    for (int i = 0; i < 4 && (exp_q.size() + exp2_q.size()) > 0; i++) @(posedge clk);
    n_checks++;
    if ((exp_q.size() + exp2_q.size()) == 0) n_pass++;
    else $display("FAIL drain pending=%0d required=0", exp_q.size() + exp2_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle MIPS control FSM; successor to the single-cycle combinational decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives datapath enables per state and handshakes with a variable-latency memory via mem_ready.
- Adds precise interrupt/exception entry: IRQ at instruction boundary, undefined instruction, memory timeout.

Parameters:
- MEM_TIMEOUT, 15, maximum cycles a memory access waits for mem_ready before a bus-timeout exception (1..255).
- IRQ_EN, 1, 0 ignores IRQ entirely.
- CNT_W, 8, wait-counter width; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- OpCode  in  6  instruction [31:26], valid from the cycle after IRWrite.
- Funct  in  6  instruction [5:0].
- IRQ  in  1  level interrupt request.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC update.
- PCWriteCond  out  1  PC update if branch condition (from ALU) true.
- IorD  out  1  0 = address from PC, 1 = address from ALUOut.
- IRWrite  out  1  load instruction register.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- RegWrite  out  1  register file write.
- RegDst  out  2  00 rt, 01 rd, 10 $ra, 11 $k0.
- MemToReg  out  2  00 ALUOut, 01 MDR, 10 PC.
- ALUSrcA  out  2  00 PC, 01 rs, 10 shamt.
- ALUSrcB  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2.
- ALUOp  out  2  00 funct-decoded, 01 sub/compare, 10 add, 11 opcode-decoded.
- PCSrc  out  3  000 ALU, 001 ALUOut, 010 jump target, 011 rs, 100 IRQ vector, 101 exception vector.
- ExtOp  out  1  1 sign-extend, 0 zero-extend.
- LuOp  out  1  load-upper select.
- EPCWrite  out  1  capture return PC into EPC.
- Cause  out  2  00 none, 01 IRQ, 10 undefined instruction, 11 bus timeout; valid while EPCWrite = 1.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset: state = IF, wait counter = 0; all outputs 0 except ALUSrcB = 01 and ExtOp = 1. A reset mid-access aborts the access immediately.
- Outputs are a Moore decode of the state. ExtOp, LuOp, RegDst and MemToReg also decode OpCode/Funct.
- IF:
  - If IRQ & IRQ_EN when entering IF, go to EXC with Cause = 01; no fetch is issued.
  - Otherwise MemRead = 1, IorD = 0, ALUSrcA = 00, ALUSrcB = 01.
  - Hold until mem_ready; in that cycle IRWrite = 1, PCWrite = 1 (PC+4), then go to ID.
- ID:
  - ALUSrcB = 11 (branch target into ALUOut).
  - Next state by opcode: R-type to EX_R; jr/jalr to JR; lw/sw to ADDR; beq/bne/blez/bgtz/bltz to BR; j/jal to JMP; addi/addiu/andi/ori/slti/sltiu/lui to EX_I.
  - Any other opcode, or R-type funct outside {00,02,03,08,09,20-27,2a,2b}: go to EXC with Cause = 10.
- EX_R: ALUSrcA = 01 (10 for funct ≤ 03), ALUSrcB = 00, ALUOp = 00; then WB_R.
- EX_I: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 11; ExtOp = 0 for 09/0b/0c/0d; LuOp for 0f; then WB_I.
- WB_R / WB_I: RegWrite = 1, RegDst = 01 / 00, MemToReg = 00; then IF.
- ADDR: ALUOp = 10, ALUSrcB = 10; lw goes to MEM_RD, sw to MEM_WR.
- MEM_RD / MEM_WR:
  - IorD = 1, MemRead / MemWrite held high until mem_ready.
  - Counter increments each waiting cycle.
  - If the counter reaches MEM_TIMEOUT without mem_ready, go to EXC with Cause = 11.
  - If mem_ready arrives on the timeout cycle itself, completion wins.
  - On completion, MEM_RD goes to WB_MEM and MEM_WR goes to IF. The counter clears on every state change.
- WB_MEM: RegWrite = 1, RegDst = 00, MemToReg = 01; then IF.
- BR: ALUOp = 01, PCWriteCond = 1, PCSrc = 001; then IF.
- JMP: PCWrite = 1, PCSrc = 010. jal also asserts RegWrite, RegDst = 10, MemToReg = 10. Then IF.
- JR: PCWrite = 1, PCSrc = 011. jalr also asserts RegWrite, RegDst = 01, MemToReg = 10. Then IF.
- EXC (one cycle):
  - EPCWrite = 1 with Cause; PCWrite = 1; PCSrc = 100 for IRQ, else 101.
  - RegWrite = 1, RegDst = 11, MemToReg = 10.
  - Then IF. IRQ is not resampled until the next IF entry, so one instruction always executes between back-to-back IRQs.
- IRQ asserted mid-instruction is ignored until the instruction boundary.

Decomposition:
- Package multicycle_pkg: state encodings (IF, ID, EX_R, EX_I, WB_R, WB_I, ADDR, MEM_RD, MEM_WR, WB_MEM, BR, JMP, JR, EXC); opcode/funct constants; PCSrc and Cause codes.
- One sub-module, inst_decode: purely combinational; OpCode/Funct to instruction class plus an undefined flag; used by ID.

Test Plan:
- addu (op 00, funct 21), mem_ready high every cycle → states IF, ID, EX_R, WB_R. Exactly 4 cycles, RegWrite only in cycle 4 with RegDst = 01.
- lw (op 23), mem_ready delayed 3 cycles on the data access → MemRead held 4 cycles in MEM_RD. WB_MEM follows with MemToReg = 01; total 8 cycles.
- sw with mem_ready never asserted, MEM_TIMEOUT = 15 → after 15 waiting cycles go to EXC with Cause = 11, EPCWrite = 1, PCSrc = 101; MemWrite deasserted afterwards.
- Opcode 0x10 or funct 0x18 → ID goes to EXC with Cause = 10, no RegWrite in ID. Next state is IF.
- IRQ raised during EX_R of add → WB_R completes normally. The next IF goes to EXC with Cause = 01 and PCSrc = 100. With IRQ held, one instruction executes before the next EXC. With IRQ_EN = 0 there is no EXC.
- reset pulsed during MEM_RD wait → the next cycle is IF with all outputs at reset values and the counter at 0.
